// File: rtl/var_table_pkg.sv
// Shared definitions for the SAT variable table bank.
//   vt_op_e    : runtime port operation encodings
//   vt_state_e : clear-sweep sequencer states
//   vt_depth   : number of table entries for a given address width
package var_table_pkg;

  typedef enum logic [1:0] {
    VT_OP_READ  = 2'b00,
    VT_OP_WRITE = 2'b01,
    VT_OP_FLIP  = 2'b10,
    VT_OP_NOP   = 2'b11
  } vt_op_e;

  typedef enum logic {
    VT_IDLE  = 1'b0,
    VT_SWEEP = 1'b1
  } vt_state_e;

  function automatic int vt_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/var_table_sweep_seq.sv
// Clear-sweep sequencer for the variable table.
// Walks every address once, driving a fill value into the storage array.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   clr, clr_val : sweep request and fill value (honoured only in idle)
//   busy         : sweep in progress
//   clr_accept   : sweep request taken this cycle
//   sweep_we     : storage write enable for the sweep
//   sweep_addr   : storage address being filled
//   sweep_data   : fill value being written
//
// state    | meaning
// ---------+-----------------------------------------------
// VT_IDLE  | table available to runtime and AXI traffic
// VT_SWEEP | writing fill value to address cnt, one per cycle
module var_table_sweep_seq
  import var_table_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              clr_val,
  output logic              busy,
  output logic              clr_accept,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(vt_depth(ADDR_W) - 1);

  vt_state_e         state;
  vt_state_e         state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              fill;

  // Reset itself launches a zero-fill sweep, so the table never holds X.
  always_ff @(posedge clk) begin
    if (rst) state <= VT_SWEEP;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      fill <= 1'b0;
    end else if (state == VT_IDLE && clr) begin
      cnt  <= '0;
      fill <= clr_val;
    end else if (state == VT_SWEEP) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      VT_IDLE:  if (clr) state_nxt = VT_SWEEP;
      VT_SWEEP: if (cnt == LAST_ADDR) state_nxt = VT_IDLE;
      default:  state_nxt = VT_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == VT_SWEEP);
    clr_accept = (state == VT_IDLE) && clr;
    sweep_we   = (state == VT_SWEEP);
    sweep_addr = cnt;
    sweep_data = fill;
  end

endmodule

// File: rtl/variable_table_bank.sv
// SAT variable assignment store: one bit per variable.
// Multi-lane registered reads for the clause-evaluation cluster, one runtime
// write/flip port, one valid/ready AXI init/debug port, a hardware clear
// sweep and a saturating flip counter.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   axi_*                   : AXI init/debug request, read response
//   en_i, op_i, wr_addr_i,
//   data_i                  : runtime enable, op, write/flip target, data
//   addr_mi, data_mo,
//   valid_o                 : packed lane addresses, lane read data, valid
//   clr_i, clr_val_i, busy_o: clear sweep request, fill value, sweep active
//   flip_count_o            : saturating count of flips since reset/clear
module variable_table_bank
  import var_table_pkg::*;
#(
  parameter int VARIABLE_ADDRESS_WIDTH = 11,
  parameter int CLUSTER_SIZE           = 40,
  parameter int FLIP_COUNT_WIDTH       = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     axi_en_i,
  output logic                                     axi_ready_o,
  input  logic                                     axi_wr_en_i,
  input  logic [VARIABLE_ADDRESS_WIDTH-1:0]        axi_addr_i,
  input  logic                                     axi_data_i,
  output logic                                     axi_rd_data_o,
  output logic                                     axi_rd_valid_o,
  input  logic                                     en_i,
  input  logic [1:0]                               op_i,
  input  logic [VARIABLE_ADDRESS_WIDTH-1:0]        wr_addr_i,
  input  logic                                     data_i,
  input  logic [CLUSTER_SIZE*VARIABLE_ADDRESS_WIDTH-1:0] addr_mi,
  output logic [CLUSTER_SIZE-1:0]                  data_mo,
  output logic                                     valid_o,
  input  logic                                     clr_i,
  input  logic                                     clr_val_i,
  output logic                                     busy_o,
  output logic [FLIP_COUNT_WIDTH-1:0]              flip_count_o
);

  localparam int W     = VARIABLE_ADDRESS_WIDTH;
  localparam int DEPTH = vt_depth(W);

  logic [DEPTH-1:0] mem;

  vt_op_e  op;
  logic    rt_active;
  logic    rt_write;
  logic    rt_flip;
  logic    axi_accept;

  logic          clr_accept;
  logic          sweep_we;
  logic [W-1:0]  sweep_addr;
  logic          sweep_data;

  logic          mem_we;
  logic [W-1:0]  mem_waddr;
  logic          mem_wdata;

  var_table_sweep_seq #(
    .ADDR_W (W)
  ) u_sweep (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (clr_i),
    .clr_val    (clr_val_i),
    .busy       (busy_o),
    .clr_accept (clr_accept),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .sweep_data (sweep_data)
  );

  assign op        = vt_op_e'(op_i);
  assign rt_active = en_i && !busy_o;
  assign rt_write  = rt_active && (op == VT_OP_WRITE);
  assign rt_flip   = rt_active && (op == VT_OP_FLIP);

  // Runtime write/flip owns the single write port; AXI is refused and must hold.
  assign axi_ready_o = !busy_o && !(en_i && (op == VT_OP_WRITE || op == VT_OP_FLIP));
  assign axi_accept  = axi_en_i && axi_ready_o;

  // At most one writer is live per cycle: sweep excludes the others via busy,
  // and AXI is only accepted when no runtime write/flip is present.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 1'b0;
    if (sweep_we) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_addr;
      mem_wdata = sweep_data;
    end else if (rt_write) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr_i;
      mem_wdata = data_i;
    end else if (rt_flip) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr_i;
      mem_wdata = ~mem[wr_addr_i];
    end else if (axi_accept && axi_wr_en_i) begin
      mem_we    = 1'b1;
      mem_waddr = axi_addr_i;
      mem_wdata = axi_data_i;
    end
  end

  // Contents are initialised by the reset-triggered sweep, not by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Reads sample the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_mo <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= rt_active;
      if (rt_active) begin
        for (int k = 0; k < CLUSTER_SIZE; k++) begin
          data_mo[k] <= mem[addr_mi[k*W +: W]];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      axi_rd_data_o  <= 1'b0;
      axi_rd_valid_o <= 1'b0;
    end else begin
      axi_rd_valid_o <= axi_accept && !axi_wr_en_i;
      if (axi_accept && !axi_wr_en_i) axi_rd_data_o <= mem[axi_addr_i];
    end
  end

  // A clear taken in the same cycle as a flip wins: the count restarts at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flip_count_o <= '0;
    end else if (clr_accept) begin
      flip_count_o <= '0;
    end else if (rt_flip && (flip_count_o != {FLIP_COUNT_WIDTH{1'b1}})) begin
      flip_count_o <= flip_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_variable_table_bank.sv
module tb_variable_table_bank;

  localparam int W   = 4;
  localparam int CS  = 4;
  localparam int FCW = 2;

  logic          clk;
  logic          rst_i;
  logic          axi_en_i;
  logic          axi_ready_o;
  logic          axi_wr_en_i;
  logic [W-1:0]  axi_addr_i;
  logic          axi_data_i;
  logic          axi_rd_data_o;
  logic          axi_rd_valid_o;
  logic          en_i;
  logic [1:0]    op_i;
  logic [W-1:0]  wr_addr_i;
  logic          data_i;
  logic [CS*W-1:0] addr_mi;
  logic [CS-1:0] data_mo;
  logic          valid_o;
  logic          clr_i;
  logic          clr_val_i;
  logic          busy_o;
  logic [FCW-1:0] flip_count_o;

  int checks = 0;
  int errors = 0;
  int n;
  bit saw_valid;
  bit saw_ready;

  variable_table_bank #(
    .VARIABLE_ADDRESS_WIDTH (W),
    .CLUSTER_SIZE           (CS),
    .FLIP_COUNT_WIDTH       (FCW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .axi_en_i       (axi_en_i),
    .axi_ready_o    (axi_ready_o),
    .axi_wr_en_i    (axi_wr_en_i),
    .axi_addr_i     (axi_addr_i),
    .axi_data_i     (axi_data_i),
    .axi_rd_data_o  (axi_rd_data_o),
    .axi_rd_valid_o (axi_rd_valid_o),
    .en_i           (en_i),
    .op_i           (op_i),
    .wr_addr_i      (wr_addr_i),
    .data_i         (data_i),
    .addr_mi        (addr_mi),
    .data_mo        (data_mo),
    .valid_o        (valid_o),
    .clr_i          (clr_i),
    .clr_val_i      (clr_val_i),
    .busy_o         (busy_o),
    .flip_count_o   (flip_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input logic [W-1:0] a0, input logic [W-1:0] a1,
                           input logic [W-1:0] a2, input logic [W-1:0] a3);
    addr_mi = {a3, a2, a1, a0};
  endtask

  // Reads four consecutive addresses with op NOP and checks the lane data.
  task automatic read4(input string tag, input logic [W-1:0] base, input logic [CS-1:0] exp);
    set_lanes(base, base + 4'd1, base + 4'd2, base + 4'd3);
    en_i = 1'b1;
    op_i = 2'b11;
    step();
    en_i = 1'b0;
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_data"}, 32'(data_mo), 32'(exp));
  endtask

  task automatic wait_sweep(output int cycles);
    cycles = 0;
    while (busy_o && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    axi_en_i = 1'b0; axi_wr_en_i = 1'b0; axi_addr_i = '0; axi_data_i = 1'b0;
    en_i = 1'b0; op_i = 2'b11; wr_addr_i = '0; data_i = 1'b0;
    addr_mi = '0; clr_i = 1'b0; clr_val_i = 1'b0;

    // 1. reset
    step();
    rst_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data_mo", 32'(data_mo), 32'd0);
    chk("rst_axi_rd_valid", 32'(axi_rd_valid_o), 32'd0);
    chk("rst_axi_rd_data", 32'(axi_rd_data_o), 32'd0);
    chk("rst_flip_count", 32'(flip_count_o), 32'd0);
    wait_sweep(n);
    chk("rst_sweep_len", 32'(n), 32'd16);
    chk("rst_busy_end", 32'(busy_o), 32'd0);
    read4("rst_read", 4'd0, 4'b0000);
    step();
    chk("valid_drop", 32'(valid_o), 32'd0);

    // 2. AXI write and read of addr 5
    axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 4'd5; axi_data_i = 1'b1;
    #1;
    chk("axi_wr_ready", 32'(axi_ready_o), 32'd1);
    step();
    axi_en_i = 1'b0;
    set_lanes(4'd5, 4'd5, 4'd5, 4'd5);
    en_i = 1'b1; op_i = 2'b00;
    step();
    en_i = 1'b0;
    chk("alias5_valid", 32'(valid_o), 32'd1);
    chk("alias5_data", 32'(data_mo), 32'hf);
    axi_en_i = 1'b1; axi_wr_en_i = 1'b0; axi_addr_i = 4'd5;
    #1;
    chk("axi_rd_ready", 32'(axi_ready_o), 32'd1);
    step();
    axi_en_i = 1'b0;
    chk("axi_rd_valid", 32'(axi_rd_valid_o), 32'd1);
    chk("axi_rd_data", 32'(axi_rd_data_o), 32'd1);
    step();
    chk("axi_rd_pulse", 32'(axi_rd_valid_o), 32'd0);

    // 3. back-to-back flips of addr 7, lane 0 reading 7
    set_lanes(4'd7, 4'd0, 4'd5, 4'd7);
    en_i = 1'b1; op_i = 2'b10; wr_addr_i = 4'd7;
    #1;
    chk("flip_blocks_axi", 32'(axi_ready_o), 32'd0);
    step();
    chk("flip1_lanes", 32'(data_mo), 32'b0100);
    chk("flip1_count", 32'(flip_count_o), 32'd1);
    step();
    chk("flip2_lanes", 32'(data_mo), 32'b1101);
    chk("flip2_count", 32'(flip_count_o), 32'd2);
    en_i = 1'b0;
    read4("flip_after", 4'd4, 4'b0010);

    // 4. runtime write vs AXI write to addr 3
    en_i = 1'b1; op_i = 2'b01; wr_addr_i = 4'd3; data_i = 1'b0;
    axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 4'd3; axi_data_i = 1'b1;
    #1;
    chk("arb_refused", 32'(axi_ready_o), 32'd0);
    step();
    set_lanes(4'd3, 4'd3, 4'd3, 4'd3);
    op_i = 2'b00;
    #1;
    chk("arb_held_ready", 32'(axi_ready_o), 32'd1);
    step();
    axi_en_i = 1'b0;
    chk("arb_read_first", 32'(data_mo), 32'h0);
    step();
    en_i = 1'b0;
    chk("arb_axi_landed", 32'(data_mo), 32'hf);

    // 5a. clear sweep with fill 1, runtime/AXI/clr traffic ignored while busy
    clr_i = 1'b1; clr_val_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("clr_busy", 32'(busy_o), 32'd1);
    chk("clr_count", 32'(flip_count_o), 32'd0);
    en_i = 1'b1; op_i = 2'b10; wr_addr_i = 4'd2;
    axi_en_i = 1'b1; axi_wr_en_i = 1'b1; axi_addr_i = 4'd4; axi_data_i = 1'b0;
    saw_valid = 1'b0; saw_ready = 1'b0;
    n = 0;
    while (busy_o && n < 40) begin
      #1;
      if (axi_ready_o) saw_ready = 1'b1;
      clr_i = (n == 5); clr_val_i = 1'b0;
      n++;
      step();
      if (valid_o) saw_valid = 1'b1;
    end
    clr_i = 1'b0; en_i = 1'b0; axi_en_i = 1'b0;
    chk("clr_sweep_len", 32'(n), 32'd16);
    chk("clr_no_valid", 32'(saw_valid), 32'd0);
    chk("clr_no_ready", 32'(saw_ready), 32'd0);
    read4("clr_fill_a", 4'd0, 4'hf);
    read4("clr_fill_b", 4'd4, 4'hf);
    read4("clr_fill_c", 4'd8, 4'hf);
    read4("clr_fill_d", 4'd12, 4'hf);
    chk("clr_count_after", 32'(flip_count_o), 32'd0);

    // 5b. reset at sweep cycle 8 restarts with fill 0
    clr_i = 1'b1; clr_val_i = 1'b1;
    step();
    clr_i = 1'b0;
    repeat (7) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_mid_busy", 32'(busy_o), 32'd1);
    wait_sweep(n);
    chk("rst_mid_len", 32'(n), 32'd16);
    read4("rst_mid_a", 4'd0, 4'h0);
    read4("rst_mid_b", 4'd4, 4'h0);
    read4("rst_mid_c", 4'd8, 4'h0);
    read4("rst_mid_d", 4'd12, 4'h0);

    // 6. five flips on addr 2, counter saturates
    en_i = 1'b1; op_i = 2'b10; wr_addr_i = 4'd2;
    step();
    step();
    chk("sat_count2", 32'(flip_count_o), 32'd2);
    step();
    step();
    step();
    en_i = 1'b0;
    chk("sat_count", 32'(flip_count_o), 32'd3);
    read4("sat_mem", 4'd0, 4'b0100);

    // nop with a write target must not modify memory
    en_i = 1'b1; op_i = 2'b11; wr_addr_i = 4'd2; data_i = 1'b0;
    set_lanes(4'd2, 4'd2, 4'd0, 4'd0);
    step();
    step();
    en_i = 1'b0;
    chk("nop_keep", 32'(data_mo), 32'b0011);
    step();
    chk("en_low_valid", 32'(valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/variable_table_bank.md
Name: variable_table_bank

Overview:
Next-generation SAT variable assignment store: one bit per variable, DEPTH = 2**VARIABLE_ADDRESS_WIDTH entries.
- Serves CLUSTER_SIZE registered read lanes, plus one runtime write/flip port and one valid/ready AXI init/debug port.
- Adds a hardware clear sweep and a saturating flip counter.
- Sits between the AXI loader and the clause-evaluation cluster in the WalkSAT datapath.

Parameters:
VARIABLE_ADDRESS_WIDTH, 11, address bits per variable; DEPTH = 2**VARIABLE_ADDRESS_WIDTH
CLUSTER_SIZE, 40, number of parallel read lanes
FLIP_COUNT_WIDTH, 32, width of the flip counter

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  synchronous active-high reset
axi_en_i  in  1  AXI request valid
axi_ready_o  out  1  AXI request accepted this cycle when axi_en_i=1
axi_wr_en_i  in  1  1=write, 0=read
axi_addr_i  in  VARIABLE_ADDRESS_WIDTH  AXI address
axi_data_i  in  1  AXI write data
axi_rd_data_o  out  1  AXI read data
axi_rd_valid_o  out  1  axi_rd_data_o valid
en_i  in  1  runtime enable
op_i  in  2  00 read-only, 01 write, 10 flip, 11 nop
wr_addr_i  in  VARIABLE_ADDRESS_WIDTH  write/flip target
data_i  in  1  runtime write data
addr_mi  in  CLUSTER_SIZE*VARIABLE_ADDRESS_WIDTH  packed read addresses; lane k = bits [k*W +: W]
data_mo  out  CLUSTER_SIZE  read data; bit k belongs to lane k
valid_o  out  1  data_mo valid
clr_i  in  1  start a clear sweep
clr_val_i  in  1  fill value for the sweep
busy_o  out  1  sweep in progress
flip_count_o  out  FLIP_COUNT_WIDTH  flips performed since the last reset or clear

Behaviour:
- Reset (rst_i=1 at an edge):
  - data_mo=0, valid_o=0, axi_rd_data_o=0, axi_rd_valid_o=0, flip_count_o=0.
  - FSM enters SWEEP with fill value 0 and sweep counter 0.
  - Reset asserted mid-sweep restarts the sweep from address 0 with fill 0.
- FSM states: IDLE and SWEEP.
  - SWEEP writes the fill value to address cnt each cycle; cnt increments.
  - After writing DEPTH-1, the FSM returns to IDLE. Sweep length is exactly DEPTH cycles.
  - busy_o = (state==SWEEP), registered.
- clr_i in IDLE:
  - Latch clr_val_i; enter SWEEP next cycle; clear flip_count_o.
  - Runtime and AXI requests in that same cycle are still serviced.
  - clr_i during SWEEP is ignored.
- While busy_o=1:
  - en_i is ignored; valid_o=0; axi_ready_o=0.
  - Memory is not otherwise modified.
- Runtime read (every cycle with en_i=1 and busy_o=0, any op):
  - Each lane reads mem[addr_k].
  - data_mo and valid_o are registered: 1-cycle latency; valid_o=1 the cycle after.
  - Read-first: a read in the same cycle as a write or flip to the same address returns the old value.
  - Lanes may alias the same address.
- Runtime write (op 01): mem[wr_addr_i] <= data_i.
- Runtime flip (op 10):
  - mem[wr_addr_i] <= ~mem[wr_addr_i].
  - flip_count_o += 1, saturating at all-ones.
  - Back-to-back flips of the same address each toggle, using the updated value.
- AXI arbitration:
  - axi_ready_o = !busy_o && !(en_i && op_i ∈ {01,10}); combinational from registered busy_o.
  - Runtime write/flip has priority. A refused AXI request must be held by the master.
  - Accepted write: mem[axi_addr_i] <= axi_data_i.
  - Accepted read: axi_rd_data_o registered next cycle, axi_rd_valid_o pulses one cycle, read-first semantics.
- op 11 or en_i=0: no memory change. valid_o=0 when en_i=0.

Decomposition:
- Package var_table_pkg:
  - op encodings VT_OP_READ, VT_OP_WRITE, VT_OP_FLIP, VT_OP_NOP
  - state enum VT_IDLE, VT_SWEEP
  - depth localparam function
- Sub-module var_table_sweep_seq: FSM, sweep counter, latched fill value, busy_o. Outputs sweep write enable, address and data to the storage array.

Test Plan:
(Configuration for all scenarios: W=4, CLUSTER_SIZE=4, DEPTH=16, FLIP_COUNT_WIDTH=2.)
1. Reset: rst_i high 1 cycle -> busy_o=1 for exactly 16 cycles, then 0. Read lanes {0,1,2,3} -> data_mo=4'b0000, valid_o=1 one cycle after.
2. AXI write addr 5 data 1 with axi_ready_o=1 -> lanes {5,5,5,5} read 4'b1111. AXI read addr 5 -> axi_rd_data_o=1, axi_rd_valid_o one-cycle pulse.
3. Flip addr 7 on two consecutive cycles, with lane 0 reading addr 7 in both cycles -> lane 0 returns 0 then 1 (read-first). Final mem[7]=0, flip_count_o=2.
4. Same cycle: runtime write addr 3 data 0 and AXI write addr 3 data 1 -> axi_ready_o=0, mem[3]=0. AXI held, accepted next cycle -> mem[3]=1.
5. clr_i with clr_val_i=1 -> busy_o 16 cycles; en_i during the sweep gives valid_o=0; afterwards all lanes read 1 and flip_count_o=0. Repeat with rst_i at sweep cycle 8 -> sweep restarts, all entries read 0 after 16 cycles.
6. Five flips on addr 2 -> flip_count_o saturates at 3; mem[2]=1.
